fifo_reader: RTL

Read-side master for the team's synchronous FIFO. It watches `empty` and issues `Read_enable`, then captures each word one cycle later. Captured words go into a 2-entry skid buffer and are presented downstream on a valid/ready stream. It sits between the FIFO's read port and any consumer, and keeps full throughput without overreading.

---
 rtl/fifo_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side master for a synchronous FIFO.
// Strobes Read_enable when space is reserved, captures data_out the
// following cycle into a 2-entry skid buffer, and presents it on a
// valid/ready stream.
// Ports: clk, reset (sync, active-high), enable, empty, data_out,
//        Read_enable, m_data, m_valid, m_ready, busy, rd_count.
// Option: FIFO_RD_COUNT_EN adds a wrapping delivered-word counter on
//         rd_count; without it rd_count is tied to 0.
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  inflight;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0]            occ;
  logic [2:0]            level;
  logic                  pop;
  logic                  capture;

  always_comb begin
    occ     = 2'd0;
    m_valid = 1'b0;
    case (state)
      S_ONE: begin
        occ     = 2'd1;
        m_valid = 1'b1;
      end
      S_TWO: begin
        occ     = 2'd2;
        m_valid = 1'b1;
      end
      default: begin
        occ     = 2'd0;
        m_valid = 1'b0;
      end
    endcase
  end

  assign pop     = m_valid & m_ready;
  assign capture = inflight;
  assign m_data  = mem[head];
  assign busy    = (state != S_EMPTY) | inflight;

  // Occupancy after this edge; a strobe now only if a slot stays free.
  // Counting the pop lets a drained word's slot be reused at once.
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign Read_enable = enable & ~empty & (level < 3'd2);

  always_comb begin
    state_nxt = state;
    case ({capture, pop})
      2'b10: begin
        case (state)
          S_EMPTY: state_nxt = S_ONE;
          default: state_nxt = S_TWO;
        endcase
      end
      2'b01: begin
        case (state)
          S_TWO:   state_nxt = S_ONE;
          default: state_nxt = S_EMPTY;
        endcase
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_EMPTY;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= Read_enable;
      // Space was reserved at issue, so capture never checks occupancy.
      if (capture) begin
        mem[tail] <= data_out;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
    end
  end

`ifdef FIFO_RD_COUNT_EN
  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (pop) count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign rd_count = count;
`else
  assign rd_count = '0;
`endif

endmodule
